sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_if.sv | 24 ++
 rtl/sram_arbiter.sv | 138 +++++++++++++
 tb/tb_sram_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the two-port SRAM arbiter.
// Each requester has its own req/we bit. Its address and write data are
// packed into the wide vectors, with requester 1 in the upper slice.
// The arbiter returns a one-hot grant, a done pulse, shared read data and busy.
interface sram_arbiter_if;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [21:0] addr;
    logic [31:0] wdata;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [15:0] rdata;
    logic        busy;

    modport master (
        output req, we, addr, wdata,
        input  gnt, done, rdata, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, done, rdata, busy
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a single asynchronous SRAM (MAR/MDR style).
// A winner is picked in IDLE and its request fields are latched. The arbiter
// then sequences ADDR -> WRITE|READ(->CAPT) -> DONE and drives the memory strobes.
// Define SRAM_ARB_RR_EN for round-robin arbitration. The default is fixed
// priority, in which requester 0 wins.
module sram_arbiter (
    input  logic          clk,
    input  logic          nReset,
    sram_arbiter_if.slave bus,
    output logic [10:0]   memAdd,
    inout  wire  [15:0]   memData,
    output logic          nMemOut,
    output logic          nMemWrite
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        CAPT  = 3'd4,
        DONE  = 3'd5
    } stateT;

    stateT       stateReg;
    logic        weReg;
    logic [15:0] wdataReg;
    logic [1:0]  gntReg;
    logic [1:0]  doneReg;
    logic [15:0] rdataReg;
    logic        winner;

    // Per-requester views of the packed address and write-data vectors.
    logic [10:0] addrArr  [2];
    logic [15:0] wdataArr [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gUnpack
            assign addrArr[gi]  = bus.addr[gi*11 +: 11];
            assign wdataArr[gi] = bus.wdata[gi*16 +: 16];
        end
    endgenerate

`ifdef SRAM_ARB_RR_EN
    // favourReg holds the requester that wins a tie. Reset favours requester 0.
    logic favourReg;

    // Round-robin pick: a tie goes to the favoured requester, otherwise to the only requester.
    always_comb begin
        winner = 1'b0;
        if (bus.req == 2'b11) begin
            winner = favourReg;
        end else begin
            winner = bus.req[1];
        end
    end

    // Favour passes to the other requester on every grant.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            favourReg <= 1'b0;
        end else if (stateReg == IDLE && (|bus.req)) begin
            favourReg <= ~winner;
        end
    end
`else
    // Fixed priority: requester 1 wins only when requester 0 is not asking.
    assign winner = ~bus.req[0];
`endif

    // Main sequencer. All memory strobes and handshake outputs are registered here.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            stateReg  <= IDLE;
            weReg     <= 1'b0;
            wdataReg  <= 16'h0000;
            gntReg    <= 2'b00;
            doneReg   <= 2'b00;
            rdataReg  <= 16'h0000;
            memAdd    <= 11'h000;
            nMemOut   <= 1'b1;
            nMemWrite <= 1'b1;
        end else begin
            unique case (stateReg)
                IDLE: begin
                    if (|bus.req) begin
                        weReg    <= bus.we[winner];
                        wdataReg <= wdataArr[winner];
                        memAdd   <= addrArr[winner];
                        gntReg   <= winner ? 2'b10 : 2'b01;
                        stateReg <= ADDR;
                    end
                end
                ADDR: begin
                    if (weReg) begin
                        nMemWrite <= 1'b0;
                        stateReg  <= WRITE;
                    end else begin
                        nMemOut  <= 1'b0;
                        stateReg <= READ;
                    end
                end
                WRITE: begin
                    nMemWrite <= 1'b1;
                    doneReg   <= gntReg;
                    stateReg  <= DONE;
                end
                READ: begin
                    stateReg <= CAPT;
                end
                CAPT: begin
                    // The SRAM output has had two full cycles to settle by this edge.
                    rdataReg <= memData;
                    nMemOut  <= 1'b1;
                    doneReg  <= gntReg;
                    stateReg <= DONE;
                end
                DONE: begin
                    doneReg  <= 2'b00;
                    gntReg   <= 2'b00;
                    stateReg <= IDLE;
                end
                default: begin
                    stateReg <= IDLE;
                end
            endcase
        end
    end

    // The arbiter drives the MDR bus only while the write strobe is low.
    assign memData = (stateReg == WRITE) ? wdataReg : 16'bz;

    assign bus.gnt   = gntReg;
    assign bus.done  = doneReg;
    assign bus.rdata = rdataReg;
    assign bus.busy  = (stateReg != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed testbench for sram_arbiter with a behavioural SRAM on the MDR bus.
// The bus keeper drives 0x5A5A whenever both strobes are high, so any stray
// drive from the arbiter shows up as a corrupted value.
module tb_sram_arbiter;

`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        nReset;
    logic [10:0] memAdd;
    wire  [15:0] memData;
    logic        nMemOut;
    logic        nMemWrite;

    sram_arbiter_if bus ();

    sram_arbiter dut (
        .clk       (clk),
        .nReset    (nReset),
        .bus       (bus),
        .memAdd    (memAdd),
        .memData   (memData),
        .nMemOut   (nMemOut),
        .nMemWrite (nMemWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM. It drives reads while nMemOut is low, otherwise the keeper drives.
    logic [15:0] sram [2048];
    assign memData = (!nMemOut) ? sram[memAdd] : (nMemWrite ? 16'h5A5A : 16'hzzzz);

    always @(posedge clk) begin
        if (!nMemWrite) sram[memAdd] <= memData;
    end

    int nChecks = 0;
    int nPass = 0;
    int expWrites = 0;

    // Protocol monitor, which runs across all tests.
    bit monEn = 1'b0;
    int protoErr = 0;
    int strobes = 0;
    int grants = 0;
    int doneCycles = 0;
    logic [1:0] gntPrev = 2'b00;

    always @(negedge clk) begin
        if (monEn) begin
            if (!nMemOut && !nMemWrite) begin
                protoErr++;
                $display("FAIL proto_overlap: nMemOut=%b nMemWrite=%b want not both 0", nMemOut, nMemWrite);
            end
            if (nMemOut && nMemWrite && memData !== 16'h5A5A) begin
                protoErr++;
                $display("FAIL proto_hiz: memData=%h want keeper 5a5a", memData);
            end
            if (!nMemOut && memData !== sram[memAdd]) begin
                protoErr++;
                $display("FAIL proto_read_contention: memData=%h want %h", memData, sram[memAdd]);
            end
            if ((bus.done & ~bus.gnt) != 2'b00) begin
                protoErr++;
                $display("FAIL proto_done_owner: done=%b gnt=%b", bus.done, bus.gnt);
            end
            if (!nMemWrite) strobes++;
            if (bus.done != 2'b00) doneCycles++;
            if (gntPrev == 2'b00 && bus.gnt != 2'b00) grants++;
            gntPrev = bus.gnt;
        end
    end

    // Issues one access, holds req until done, then returns once the arbiter is back in IDLE.
    task automatic run_access(input int who, input logic isWrite, input logic [10:0] a,
                              input logic [15:0] d, output int lat, output logic [1:0] g,
                              output logic [15:0] rd);
        lat = 0;
        g = 2'b00;
        rd = 16'h0000;
        bus.we[who] = isWrite;
        bus.addr[who*11 +: 11] = a;
        bus.wdata[who*16 +: 16] = d;
        bus.req[who] = 1'b1;
        if (isWrite) expWrites++;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) g = bus.gnt;
            if (bus.done[who]) break;
        end
        if (!bus.done[who]) lat = 99;
        rd = bus.rdata;
        bus.req[who] = 1'b0;
        @(posedge clk); #1;
        $display("access req%0d %s addr=%h wdata=%h gnt=%b lat=%0d rdata=%h",
                 who, isWrite ? "WR" : "RD", a, d, g, lat, rd);
    endtask

    task automatic test_reset;
        nReset = 1'b0;
        bus.req = 2'b00;
        bus.we = 2'b00;
        bus.addr = 22'h0;
        bus.wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        nChecks++; if (bus.gnt !== 2'b00) $display("FAIL reset_gnt: got %b want 00", bus.gnt); else nPass++;
        nChecks++; if (bus.done !== 2'b00) $display("FAIL reset_done: got %b want 00", bus.done); else nPass++;
        nChecks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else nPass++;
        nChecks++; if (bus.rdata !== 16'h0000) $display("FAIL reset_rdata: got %h want 0000", bus.rdata); else nPass++;
        nChecks++; if (memAdd !== 11'h000) $display("FAIL reset_memAdd: got %h want 000", memAdd); else nPass++;
        nChecks++; if (nMemOut !== 1'b1) $display("FAIL reset_nMemOut: got %b want 1", nMemOut); else nPass++;
        nChecks++; if (nMemWrite !== 1'b1) $display("FAIL reset_nMemWrite: got %b want 1", nMemWrite); else nPass++;
        nChecks++; if (memData !== 16'h5A5A) $display("FAIL reset_memData_hiz: got %h want 5a5a", memData); else nPass++;
        nReset = 1'b1;
        monEn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read;
        int lat;
        logic [1:0] g;
        logic [15:0] rd;
        run_access(0, 1'b1, 11'h005, 16'h1234, lat, g, rd);
        nChecks++; if (lat != 3) $display("FAIL wr_latency: got %0d want 3", lat); else nPass++;
        nChecks++; if (g !== 2'b01) $display("FAIL wr_gnt: got %b want 01", g); else nPass++;
        run_access(0, 1'b0, 11'h005, 16'h0000, lat, g, rd);
        nChecks++; if (lat != 4) $display("FAIL rd_latency: got %0d want 4", lat); else nPass++;
        nChecks++; if (rd !== 16'h1234) $display("FAIL rd_data: got %h want 1234", rd); else nPass++;
        nChecks++; if (g !== 2'b01) $display("FAIL rd_gnt: got %b want 01", g); else nPass++;
        nChecks++; if (memAdd !== 11'h005) $display("FAIL idle_memAdd_hold: got %h want 005", memAdd); else nPass++;
    endtask

    task automatic test_boundary;
        int lat;
        logic [1:0] g;
        logic [15:0] rd;
        run_access(0, 1'b1, 11'h000, 16'hBEEF, lat, g, rd);
        run_access(1, 1'b1, 11'h7FF, 16'hCAFE, lat, g, rd);
        nChecks++; if (g !== 2'b10) $display("FAIL bnd_gnt1: got %b want 10", g); else nPass++;
        run_access(1, 1'b0, 11'h000, 16'h0000, lat, g, rd);
        nChecks++; if (rd !== 16'hBEEF) $display("FAIL bnd_rd_000: got %h want beef", rd); else nPass++;
        run_access(0, 1'b0, 11'h7FF, 16'h0000, lat, g, rd);
        nChecks++; if (rd !== 16'hCAFE) $display("FAIL bnd_rd_7ff: got %h want cafe", rd); else nPass++;
        nChecks++; if (memAdd !== 11'h7FF) $display("FAIL bnd_memAdd: got %h want 7ff", memAdd); else nPass++;
        repeat (3) @(posedge clk);
        #1;
        nChecks++; if (bus.rdata !== 16'hCAFE) $display("FAIL rdata_hold: got %h want cafe", bus.rdata); else nPass++;
    endtask

    // Requester 1 drops req and scrambles its fields right after the latch edge.
    task automatic test_drop_req;
        int lat;
        logic [1:0] g;
        logic [15:0] rd;
        run_access(1, 1'b1, 11'h321, 16'h0BAD, lat, g, rd);
        bus.we[1] = 1'b1;
        bus.addr[21:11] = 11'h123;
        bus.wdata[31:16] = 16'h4321;
        bus.req[1] = 1'b1;
        expWrites++;
        lat = 0;
        @(posedge clk); #1;
        lat++;
        bus.req[1] = 1'b0;
        bus.we[1] = 1'b0;
        bus.addr[21:11] = 11'h321;
        bus.wdata[31:16] = 16'hFFFF;
        while (lat < 20 && !bus.done[1]) begin
            @(posedge clk); #1;
            lat++;
        end
        nChecks++; if (lat != 3) $display("FAIL drop_done_latency: got %0d want 3", lat); else nPass++;
        @(posedge clk); #1;
        $display("access req1 WR addr=123 wdata=4321 req dropped after latch lat=%0d", lat);
        run_access(1, 1'b0, 11'h123, 16'h0000, lat, g, rd);
        nChecks++; if (rd !== 16'h4321) $display("FAIL drop_rd_latched_addr: got %h want 4321", rd); else nPass++;
        run_access(1, 1'b0, 11'h321, 16'h0000, lat, g, rd);
        nChecks++; if (rd !== 16'h0BAD) $display("FAIL drop_rd_other_addr: got %h want 0bad", rd); else nPass++;
    endtask

    task automatic test_reset_mid_write;
        int lat;
        int cyc;
        int bad;
        logic [1:0] g;
        logic [15:0] rd;
        bus.we[0] = 1'b1;
        bus.addr[10:0] = 11'h010;
        bus.wdata[15:0] = 16'h7777;
        bus.req[0] = 1'b1;
        expWrites++;
        cyc = 0;
        while (cyc < 10 && nMemWrite !== 1'b0) begin
            @(posedge clk); #1;
            cyc++;
        end
        nChecks++; if (nMemWrite !== 1'b0) $display("FAIL rst_reach_write: nMemWrite=%b want 0 within 10 cycles", nMemWrite); else nPass++;
        nReset = 1'b0;
        bus.req = 2'b00;
        @(posedge clk); #1;
        nChecks++; if (bus.busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", bus.busy); else nPass++;
        nChecks++; if (nMemWrite !== 1'b1) $display("FAIL rst_mid_nMemWrite: got %b want 1", nMemWrite); else nPass++;
        nChecks++; if (bus.done !== 2'b00) $display("FAIL rst_mid_done: got %b want 00", bus.done); else nPass++;
        nChecks++; if (bus.gnt !== 2'b00) $display("FAIL rst_mid_gnt: got %b want 00", bus.gnt); else nPass++;
        nChecks++; if (memData !== 16'h5A5A) $display("FAIL rst_mid_memData_hiz: got %h want 5a5a", memData); else nPass++;
        nReset = 1'b1;
        bus.wdata[15:0] = 16'hDEAD;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.done !== 2'b00 || nMemWrite !== 1'b1) bad++;
        end
        nChecks++; if (bad != 0) $display("FAIL rst_quiet_after: got %0d active cycles want 0", bad); else nPass++;
        $display("access req0 WR addr=010 wdata=7777 aborted by reset");
        run_access(0, 1'b0, 11'h010, 16'h0000, lat, g, rd);
        nChecks++; if (rd !== 16'h7777) $display("FAIL rst_readback: got %h want 7777", rd); else nPass++;
    endtask

    // Both requesters are held for four transactions. This checks grant order and the one-cycle IDLE gap.
    task automatic test_simultaneous;
        int owners[4];
        int gaps[3];
        int n;
        int idle;
        int cyc;
        nReset = 1'b0;
        @(posedge clk); #1;
        nReset = 1'b1;
        for (int i = 0; i < 3; i++) gaps[i] = -1;
        for (int i = 0; i < 4; i++) owners[i] = -1;
        bus.we = 2'b00;
        bus.addr = {11'h7FF, 11'h000};
        bus.req = 2'b11;
        n = 0;
        idle = 0;
        cyc = 0;
        while (n < 4 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (!bus.busy) begin
                idle++;
            end else if (idle != 0) begin
                if (n > 0 && n <= 3) gaps[n-1] = idle;
                idle = 0;
            end
            if (bus.done != 2'b00) begin
                owners[n] = bus.done[1] ? 1 : 0;
                $display("access req%0d RD simultaneous grant #%0d rdata=%h", owners[n], n, bus.rdata);
                n++;
            end
        end
        bus.req = 2'b00;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            nChecks++;
            if (owners[i] != (RR ? (i % 2) : 0))
                $display("FAIL sim_owner%0d: got %0d want %0d", i, owners[i], RR ? (i % 2) : 0);
            else nPass++;
        end
        for (int i = 0; i < 3; i++) begin
            nChecks++;
            if (gaps[i] != 1) $display("FAIL sim_gap%0d: got %0d idle cycles want 1", i, gaps[i]);
            else nPass++;
        end
    endtask

    task automatic test_protocol;
        nChecks++; if (protoErr != 0) $display("FAIL proto_violations: got %0d want 0", protoErr); else nPass++;
        nChecks++; if (doneCycles != grants - 1) $display("FAIL proto_done_per_grant: got %0d done cycles want %0d", doneCycles, grants - 1); else nPass++;
        nChecks++; if (strobes != expWrites) $display("FAIL proto_strobes: got %0d want %0d", strobes, expWrites); else nPass++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_boundary();
        test_drop_req();
        test_reset_mid_write();
        test_simultaneous();
        test_protocol();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
